// File: rtl/design_sel_ctrl.sv
// Boot-time design selector: synchronises and debounces the selection pins, then
// locks a value onto the multiplexer's design_sel bus, parking it at 5'h1F otherwise.
module design_sel_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned FILTER_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic [4:0] sel_pins_i,
  input  logic       reselect_i,
  output logic [4:0] design_sel_o,
  output logic       sel_valid_o,
  output logic [1:0] state_o,
  output logic [7:0] restarts_o
);

  localparam int unsigned SEL_W = 5;
  localparam int unsigned CNT_W = 8;

  localparam logic [SEL_W-1:0] IDLE_SEL    = SEL_W'(5'h1F);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_FILTER = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  logic [SEL_W-1:0] sync_meta_q;
  logic [SEL_W-1:0] sync_q;

  state_t           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [SEL_W-1:0] cand_q,     cand_d;
  logic [SEL_W-1:0] sel_q,      sel_d;
  logic             valid_q,    valid_d;
  logic [CNT_W-1:0] restarts_q, restarts_d;

  // Two-flop synchroniser; resets to the idle code so an early sample looks parked.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= IDLE_SEL;
      sync_q      <= IDLE_SEL;
    end else begin
      sync_meta_q <= sel_pins_i;
      sync_q      <= sync_meta_q;
    end
  end

  // State and registered-output flops.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PARK;
      cnt_q      <= '0;
      cand_q     <= IDLE_SEL;
      sel_q      <= IDLE_SEL;
      valid_q    <= 1'b0;
      restarts_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      restarts_q <= restarts_d;
    end
  end

  // Next-state logic: settle, debounce, lock, and re-selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    restarts_d = restarts_q;

    unique case (state_q)
      ST_PARK: begin
        sel_d   = IDLE_SEL;
        valid_d = 1'b0;
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_FILTER;
          cand_d  = sync_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_FILTER: begin
        // A pin change wins over a would-be lock on the same edge.
        if (sync_q != cand_q) begin
          cand_d = sync_q;
          cnt_d  = '0;
          if (restarts_q != CNT_MAX) begin
            restarts_d = restarts_q + CNT_W'(1);
          end
        end else if (cnt_q == FILTER_LAST) begin
          state_d = ST_RUN;
          sel_d   = cand_q;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (reselect_i) begin
          state_d = ST_PARK;
          sel_d   = IDLE_SEL;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_PARK;
        sel_d   = IDLE_SEL;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign design_sel_o = sel_q;
  assign sel_valid_o  = valid_q;
  assign state_o      = state_q;
  assign restarts_o   = restarts_q;

endmodule
